// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatcher: FSM state,
// channel count and the cyclic channel search.
package rr_dispatch_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // First enabled channel at or after ptr, wrapping around; returns ptr if none is enabled.
  function automatic logic [1:0] next_chan(input logic [NCH-1:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    next_chan = ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (mask[idx]) next_chan = idx;
    end
  endfunction

endpackage

// File: rtl/fifo_sinc.sv
// Synchronous single-clock FIFO with show-ahead head word. DEPTH must be a power of 2 (>= 2);
// pointers wrap naturally and an occupancy counter resolves full/empty.
module fifo_sinc #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rr_dispatch.sv
// Round-robin dispatcher: buffers upstream words and hands each one to the next
// enabled consumer channel, holding the transfer until that channel acknowledges.
module rr_dispatch
  import rr_dispatch_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH-1:0]   mask,
  output logic [WIDTH-1:0] dado,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic [NCH-1:0]   ack,
  output logic [7:0]       enviados
);

  state_t           state;
  logic [1:0]       ptr;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  // The word stays in the FIFO while in flight; it leaves only when its channel accepts it.
  assign fifo_pop  = (state == SEND) & ack[sel];

  fifo_sinc #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (entrada),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      dado      <= '0;
      sel       <= 2'd0;
      out_valid <= 1'b0;
      enviados  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && (mask != '0)) begin
            dado      <= fifo_head;
            sel       <= next_chan(mask, ptr);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Mask changes are ignored here; only the selected channel's ack completes the transfer.
          if (ack[sel]) begin
            ptr       <= sel + 2'd1;
            enviados  <= enviados + 8'd1;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_dispatch.sv
// Directed bench for rr_dispatch with a scoreboard of expected (sel, dado) deliveries.
module tb_rr_dispatch;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] data;
  } tx_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] entrada = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] mask = 4'b0000;
  logic [3:0] dado;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;
  logic [7:0] enviados;

  logic       auto_ack = 1'b0;
  logic [3:0] manual_ack = 4'b0000;

  int checks = 0;
  int failures = 0;
  tx_t expq[$];

  rr_dispatch #(.WIDTH(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .entrada  (entrada),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mask     (mask),
    .dado     (dado),
    .sel      (sel),
    .out_valid(out_valid),
    .ack      (ack),
    .enviados (enviados)
  );

  always #5 clk = ~clk;

  // Consumer model: either accept immediately on the addressed channel or use a fixed pattern.
  assign ack = auto_ack ? (out_valid ? (4'b0001 << sel) : 4'b0000) : manual_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a delivery completes at the coming edge when out_valid and ack[sel] are both high.
  always @(negedge clk) begin
    if (!reset && out_valid && ack[sel]) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual=sel%0d/%0h required=none", sel, dado);
      end else begin
        tx_t e;
        e = expq.pop_front();
        chk("delivery_sel", 32'(sel), 32'(e.sel));
        chk("delivery_dado", 32'(dado), 32'(e.data));
      end
    end
  end

  task automatic expect_tx(input logic [1:0] s, input logic [3:0] d);
    tx_t e;
    e.sel = s;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_word(input logic [3:0] w);
    bit done;
    done = 1'b0;
    entrada = w;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(expq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dado", 32'(dado), 32'd0);
    chk("rst_enviados", 32'(enviados), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // All channels enabled: strict rotation 0,1,2,3,0
    mask = 4'b1111;
    auto_ack = 1'b1;
    expect_tx(2'd0, 4'h1);
    expect_tx(2'd1, 4'h2);
    expect_tx(2'd2, 4'h3);
    expect_tx(2'd3, 4'h4);
    expect_tx(2'd0, 4'h5);
    for (int i = 1; i <= 5; i++) push_word(4'(i));
    wait_drain();
    chk("rot_enviados", 32'(enviados), 32'd5);

    // Sparse mask 1010: channels 1 and 3 only
    do_reset();
    mask = 4'b1010;
    expect_tx(2'd1, 4'h7);
    expect_tx(2'd3, 4'h8);
    expect_tx(2'd1, 4'h9);
    push_word(4'h7);
    push_word(4'h8);
    push_word(4'h9);
    wait_drain();
    chk("sparse_enviados", 32'(enviados), 32'd3);

    // Backpressure: no ack, FIFO fills after 4 words
    do_reset();
    mask = 4'b1111;
    auto_ack = 1'b0;
    manual_ack = 4'b0000;
    expect_tx(2'd0, 4'hA);
    expect_tx(2'd1, 4'hB);
    expect_tx(2'd2, 4'hC);
    expect_tx(2'd3, 4'hD);
    expect_tx(2'd0, 4'hE);
    expect_tx(2'd1, 4'hF);
    push_word(4'hA);
    push_word(4'hB);
    push_word(4'hC);
    push_word(4'hD);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    entrada = 4'hE;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(in_ready), 32'd0);
      chk("full_hold_dado", 32'(dado), 32'hA);
      chk("full_hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    auto_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("full_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_word(4'hF);
    wait_drain();
    chk("full_enviados", 32'(enviados), 32'd6);

    // mask == 0 stalls dispatch; enabling channel 2 releases it
    do_reset();
    mask = 4'b0000;
    expect_tx(2'd2, 4'hA);
    expect_tx(2'd2, 4'hB);
    push_word(4'hA);
    push_word(4'hB);
    repeat (3) begin
      @(negedge clk);
      chk("mask0_out_valid", 32'(out_valid), 32'd0);
    end
    mask = 4'b0100;
    wait_drain();
    chk("mask0_enviados", 32'(enviados), 32'd2);

    // Asynchronous reset in the middle of a SEND with 3 words queued
    mask = 4'b1111;
    auto_ack = 1'b0;
    manual_ack = 4'b0000;
    push_word(4'h1);
    push_word(4'h2);
    push_word(4'h3);
    @(negedge clk);
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    chk("arst_pre_enviados", 32'(enviados), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
    chk("arst_enviados", 32'(enviados), 32'd0);
    chk("arst_dado", 32'(dado), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_rel_ready", 32'(in_ready), 32'd1);
    chk("arst_rel_enviados", 32'(enviados), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_resend", 32'(out_valid), 32'd0);
    end

    // Only ack[sel] counts
    mask = 4'b0010;
    manual_ack = 4'b1101;
    expect_tx(2'd1, 4'h6);
    push_word(4'h6);
    repeat (3) begin
      @(negedge clk);
      chk("ackx_valid", 32'(out_valid), 32'd1);
      chk("ackx_enviados", 32'(enviados), 32'd0);
    end
    @(posedge clk);
    #1;
    manual_ack = 4'b0010;
    @(posedge clk);
    #1;
    manual_ack = 4'b0000;
    chk("ackx_pop_enviados", 32'(enviados), 32'd1);
    chk("ackx_pop_valid", 32'(out_valid), 32'd0);
    chk("final_queue", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_dispatch.md
RR_DISPATCH -- requirements
Module: rr_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the input FIFO depth in words (power of 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port entrada, input, WIDTH, the upstream data word.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port mask, input, 4, the per-channel enable (bit i enables channel i).
REQ-009 SHALL have port dado, output, WIDTH, the word presented to the downstream 1:4 demux.
REQ-010 SHALL have port sel, output, 2, the destination channel index for dado.
REQ-011 SHALL have port out_valid, output, 1, meaning dado/sel hold a transfer in progress.
REQ-012 SHALL have port ack, input, 4, the per-channel accept strobe from the consumers.
REQ-013 SHALL have port enviados, output, 8, the count of completed deliveries.

Function
REQ-014 SHALL push entrada into the FIFO at a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL drive in_ready = not full; no write bypass when full, even if a pop occurs in the same cycle.
REQ-016 SHALL perform a simultaneous push and pop, when not full, in one cycle with the occupancy unchanged.
REQ-017 SHALL implement FSM states IDLE and SEND.
REQ-018 SHALL, in IDLE, when the FIFO is non-empty and mask != 0, load dado = FIFO head and sel = first enabled channel searching cyclically from ptr (inclusive), then enter SEND.
REQ-019 SHALL remain in IDLE with out_valid = 0 while the FIFO is empty or mask == 0.
REQ-020 SHALL hold out_valid = 1 and keep dado/sel stable throughout SEND.
REQ-021 SHALL, in SEND, at the edge where ack[sel] = 1: pop the FIFO, set ptr = (sel+1) mod 4, increment enviados, and return to IDLE.
REQ-022 SHALL ignore ack bits other than ack[sel].
REQ-023 SHALL not abort a SEND in progress when mask changes (including clearing mask[sel]); the new mask applies at the next IDLE selection.
REQ-024 SHALL have a latency of one edge from a push into an empty FIFO to out_valid = 1, and a minimum gap of one IDLE cycle between consecutive deliveries.
REQ-025 SHALL wrap enviados from 255 to 0.

Reset
REQ-026 SHALL, while reset = 1, force state = IDLE, FIFO empty, ptr = 0, dado = 0, sel = 0, out_valid = 0, enviados = 0, and in_ready = 1 once reset is released.
REQ-027 SHALL, on reset assertion mid-SEND, discard the in-flight word and all FIFO contents immediately, without waiting for a clock edge.

Structure
REQ-028 SHALL define the FSM state type (IDLE, SEND) and the channel count 4 in a shared package rr_dispatch_pkg.
REQ-029 SHALL implement the FIFO as one sub-module, fifo_sinc (WIDTH, DEPTH, push/pop/full/empty), instantiated once.

Verification
REQ-030 SHALL verify: mask = 4'b1111, push 0x1,0x2,0x3,0x4,0x5, ack each immediately -> sel = 0,1,2,3,0 with dado = 0x1..0x5, enviados = 5.
REQ-031 SHALL verify: mask = 4'b1010, push 0x7,0x8,0x9 -> sel = 1,3,1.
REQ-032 SHALL verify: ack withheld, push 6 words -> in_ready = 0 after 4 words are stored (DEPTH = 4), dado = first word held stable; then ack -> in_ready returns to 1.
REQ-033 SHALL verify: mask = 0 with 2 words queued -> out_valid stays 0; set mask = 4'b0100 -> sel = 2, dado = first word.
REQ-034 SHALL verify: reset asserted in SEND with 3 words queued -> out_valid = 0 and FIFO empty with no clock edge; after release, in_ready = 1 and enviados = 0.
REQ-035 SHALL verify: ack = 4'b1101 while sel = 1 -> no pop; then ack = 4'b0010 -> pop, enviados incremented by 1.
